// File: rtl/fc_pkg.sv
// Shared widths and state encoding for the FC output packer.
// Optional build macro: FC_RELU_EN (ReLU clamp instead of signed saturation).
package fc_pkg;

    localparam int unsigned PACK_NUM   = 20;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned IN_WIDTH   = 23;
    localparam int unsigned BIAS_WIDTH = 16;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned TOTAL_W    = 10;
    localparam int unsigned SHIFT_W    = 4;
    localparam int unsigned SUM_WIDTH  = 24;
    localparam int unsigned SLOT_W     = 5;
    localparam int unsigned WORD_W     = PACK_NUM * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fc_state_e;

endpackage

// File: rtl/fc_output_packer_if.sv
// Controller-facing command/data bus and SRAM write port of the packer.
interface fc_output_packer_if import fc_pkg::*; ();

    logic                           start;
    logic [ADDR_W-1:0]              base_addr;
    logic [TOTAL_W-1:0]             out_total;
    logic [SHIFT_W-1:0]             shift;
    logic                           data_valid;
    logic signed [IN_WIDTH-1:0]     data_in;
    logic signed [BIAS_WIDTH-1:0]   bias;
    logic                           sram_wen;
    logic [ADDR_W-1:0]              sram_waddr;
    logic [WORD_W-1:0]              sram_wdata;
    logic                           busy;
    logic                           done;

    modport master (
        output start, base_addr, out_total, shift, data_valid, data_in, bias,
        input  sram_wen, sram_waddr, sram_wdata, busy, done
    );

    modport slave (
        input  start, base_addr, out_total, shift, data_valid, data_in, bias,
        output sram_wen, sram_waddr, sram_wdata, busy, done
    );

endinterface

// File: rtl/fc_requant.sv
// Bias add, round-half-up, arithmetic shift and clamp to one output byte.
// FC_RELU_EN selects a [0,127] ReLU clamp; otherwise signed [-128,127].
module fc_requant import fc_pkg::*; (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         en,
    input  logic [SHIFT_W-1:0]           shift,
    input  logic signed [IN_WIDTH-1:0]   data_in,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    output logic [DATA_WIDTH-1:0]        byte_c
);

    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'(127);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = SUM_WIDTH'(-128);

    logic signed [SUM_WIDTH-1:0] din_x;
    logic signed [SUM_WIDTH-1:0] bias_x;
    logic signed [SUM_WIDTH-1:0] sum_c;
    logic signed [SUM_WIDTH-1:0] rnd_c;
    logic signed [SUM_WIDTH-1:0] shr_c;
    logic signed [SUM_WIDTH-1:0] shr_q;

    assign din_x  = {{(SUM_WIDTH-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
    assign bias_x = {{(SUM_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};

    // Sum, add half an LSB of the result, then arithmetic shift.
    always_comb begin
        sum_c = din_x + bias_x;
        rnd_c = sum_c;
        if (shift != '0) begin
            rnd_c = sum_c + (SUM_WIDTH'(1) << (shift - SHIFT_W'(1)));
        end
        shr_c = rnd_c >>> shift;
    end

    // Stage-1 register: shifted value, loaded only for accepted inputs.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            shr_q <= '0;
        end else if (en) begin
            shr_q <= shr_c;
        end
    end

    // Clamp the registered value to one byte.
    always_comb begin
`ifdef FC_RELU_EN
        if (shr_q < SUM_WIDTH'(0)) begin
            byte_c = '0;
        end else if (shr_q > SAT_MAX) begin
            byte_c = DATA_WIDTH'(127);
        end else begin
            byte_c = shr_q[DATA_WIDTH-1:0];
        end
`else
        if (shr_q < SAT_MIN) begin
            byte_c = DATA_WIDTH'(8'h80);
        end else if (shr_q > SAT_MAX) begin
            byte_c = DATA_WIDTH'(8'h7f);
        end else begin
            byte_c = shr_q[DATA_WIDTH-1:0];
        end
`endif
    end

endmodule

// File: rtl/fc_output_packer.sv
// Requantizes FC accumulator sums and packs PACK_NUM bytes per SRAM write,
// element 0 in the most significant byte.
// Optional build macro: FC_RELU_EN (handled inside fc_requant).
module fc_output_packer import fc_pkg::*; (
    input  logic               clk,
    input  logic               srstn,
    fc_output_packer_if.slave  bus
);

    fc_state_e               state;
    logic [TOTAL_W-1:0]      total_q;
    logic [TOTAL_W-1:0]      recv_cnt;
    logic [SHIFT_W-1:0]      shift_q;
    logic [ADDR_W-1:0]       wr_addr;
    logic [SLOT_W-1:0]       slot;
    logic [WORD_W-1:0]       pack_buf;
    logic                    s1_vld;
    logic                    s1_last;
    logic                    word_full;
    logic                    word_last;

    logic                    accept_c;
    logic                    last_in_c;
    logic                    slot_full_c;
    logic [DATA_WIDTH-1:0]   q_byte_c;
    logic [WORD_W-1:0]       buf_next_c;

    assign accept_c    = (state == RUN) && bus.data_valid && !bus.start && (recv_cnt < total_q);
    assign last_in_c   = (recv_cnt == (total_q - TOTAL_W'(1)));
    assign slot_full_c = (slot == SLOT_W'(PACK_NUM - 1));

    fc_requant u_requant (
        .clk     (clk),
        .srstn   (srstn),
        .en      (accept_c),
        .shift   (shift_q),
        .data_in (bus.data_in),
        .bias    (bus.bias),
        .byte_c  (q_byte_c)
    );

    // Next pack buffer: a word handed to the write stage frees the buffer
    // so the incoming byte lands in slot 0 of a clean word.
    always_comb begin
        buf_next_c = word_full ? '0 : pack_buf;
        for (int unsigned i = 0; i < PACK_NUM; i++) begin
            if (slot == SLOT_W'(i)) begin
                buf_next_c[DATA_WIDTH*(PACK_NUM-1-i) +: DATA_WIDTH] = q_byte_c;
            end
        end
    end

    // Layer FSM, busy flag and input counter.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            total_q  <= '0;
            shift_q  <= '0;
            recv_cnt <= '0;
        end else if (bus.start) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            total_q  <= bus.out_total;
            shift_q  <= bus.shift;
            recv_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                end
                RUN: begin
                    if (accept_c) begin
                        recv_cnt <= recv_cnt + TOTAL_W'(1);
                        if (last_in_c) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (word_full && word_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pipeline valids, pack buffer and SRAM write register.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            s1_vld         <= 1'b0;
            s1_last        <= 1'b0;
            word_full      <= 1'b0;
            word_last      <= 1'b0;
            slot           <= '0;
            pack_buf       <= '0;
            wr_addr        <= '0;
            bus.sram_wen   <= 1'b1;
            bus.sram_waddr <= '0;
            bus.sram_wdata <= '0;
            bus.done       <= 1'b0;
        end else if (bus.start) begin
            s1_vld       <= 1'b0;
            s1_last      <= 1'b0;
            word_full    <= 1'b0;
            word_last    <= 1'b0;
            slot         <= '0;
            pack_buf     <= '0;
            wr_addr      <= bus.base_addr;
            bus.sram_wen <= 1'b1;
            bus.done     <= 1'b0;
        end else begin
            s1_vld  <= accept_c;
            s1_last <= accept_c && last_in_c;

            bus.sram_wen <= !word_full;
            bus.done     <= word_full && word_last;
            if (word_full) begin
                bus.sram_waddr <= wr_addr;
                bus.sram_wdata <= pack_buf;
                wr_addr        <= wr_addr + ADDR_W'(1);
            end

            if (s1_vld) begin
                pack_buf  <= buf_next_c;
                word_full <= slot_full_c || s1_last;
                word_last <= s1_last;
                slot      <= (slot_full_c || s1_last) ? '0 : slot + SLOT_W'(1);
            end else begin
                word_full <= 1'b0;
                word_last <= 1'b0;
                if (word_full) begin
                    pack_buf <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_output_packer.sv
// Randomized self-checking bench for fc_output_packer with a queue-based
// reference model of the expected SRAM writes.
module tb_fc_output_packer;
    import fc_pkg::*;

    localparam int unsigned CW = WORD_W;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [CW-1:0]     data;
        bit                last;
    } exp_t;

    logic clk   = 1'b0;
    logic srstn = 1'b0;
    always #5 clk = ~clk;

    fc_output_packer_if bus();

    fc_output_packer dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    exp_t              expq[$];
    bit                m_active = 1'b0;
    int                m_recv   = 0;
    int                m_total  = 0;
    int                m_shift  = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [7:0]        m_bytes[$];

    int t_base  = 0;
    int t_total = 0;
    int t_shift = 0;

    function automatic logic [7:0] ref_q(input int d, input int b, input int sh);
        int s;
        s = d + b;
        if (sh > 0) s = s + (1 << (sh - 1));
        s = s >>> sh;
`ifdef FC_RELU_EN
        if (s < 0)   return 8'h00;
        if (s > 127) return 8'h7f;
`else
        if (s < -128) return 8'h80;
        if (s > 127)  return 8'h7f;
`endif
        return 8'(s);
    endfunction

    function automatic int rnd_data();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 600)) - 300;
        return int'($urandom_range(0, (1 << 23) - 1)) - (1 << 22);
    endfunction

    function automatic int rnd_bias();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 200)) - 100;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drop_future();
        while (expq.size() > 0 && expq[$].cyc > cyc) void'(expq.pop_back());
    endtask

    task automatic model_start();
        drop_future();
        m_active = 1'b1;
        m_recv   = 0;
        m_total  = t_total;
        m_shift  = t_shift;
        m_addr   = ADDR_W'(t_base);
        m_bytes.delete();
    endtask

    task automatic model_accept(input int d, input int b);
        exp_t e;
        m_bytes.push_back(ref_q(d, b, m_shift));
        m_recv++;
        if (m_bytes.size() == PACK_NUM || m_recv == m_total) begin
            e.data = '0;
            for (int i = 0; i < m_bytes.size(); i++) e.data[CW-8*(i+1) +: 8] = m_bytes[i];
            e.cyc  = cyc + 3;
            e.addr = m_addr;
            e.last = (m_recv == m_total);
            expq.push_back(e);
            m_addr = m_addr + ADDR_W'(1);
            m_bytes.delete();
            if (e.last) m_active = 1'b0;
        end
    endtask

    // One cycle of stimulus; called at a negedge, returns at the next one.
    task automatic drive(input bit st, input bit dv, input int d, input int b);
        bus.start      = st;
        bus.data_valid = dv;
        bus.data_in    = IN_WIDTH'(d);
        bus.bias       = BIAS_WIDTH'(b);
        if (st) begin
            bus.base_addr = ADDR_W'(t_base);
            bus.out_total = TOTAL_W'(t_total);
            bus.shift     = SHIFT_W'(t_shift);
            model_start();
        end else if (dv && m_active && m_recv < m_total) begin
            model_accept(d, b);
        end
        @(negedge clk);
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        srstn          = 1'b0;
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        drop_future();
        m_active = 1'b0;
        @(negedge clk);
        check_eq("rst_wen",   CW'(bus.sram_wen),   CW'(1));
        check_eq("rst_waddr", CW'(bus.sram_waddr), CW'(0));
        check_eq("rst_wdata", bus.sram_wdata,      CW'(0));
        check_eq("rst_busy",  CW'(bus.busy),       CW'(0));
        check_eq("rst_done",  CW'(bus.done),       CW'(0));
        srstn = 1'b1;
    endtask

    // Write monitor
    int                n_wr = 0;
    int                n_done = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [CW-1:0]     last_wdata = '0;

    always @(negedge clk) begin
        exp_t e;
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            check_eq("write_missing_cyc", CW'(cyc), CW'(expq[0].cyc));
            void'(expq.pop_front());
        end
        if (bus.sram_wen === 1'b0) begin
            n_wr++;
            last_waddr = bus.sram_waddr;
            last_wdata = bus.sram_wdata;
            if (expq.size() == 0) begin
                check_eq("unexpected_write_wen", CW'(bus.sram_wen), CW'(1));
            end else begin
                e = expq.pop_front();
                check_eq("wr_cycle", CW'(cyc),            CW'(e.cyc));
                check_eq("wr_addr",  CW'(bus.sram_waddr), CW'(e.addr));
                check_eq("wr_data",  bus.sram_wdata,      e.data);
                check_eq("wr_done",  CW'(bus.done),       CW'(e.last));
            end
        end else begin
            check_eq("done_without_write", CW'(bus.done), CW'(0));
        end
        if (bus.done === 1'b1) n_done++;
    end

    initial begin
        int nw0;
        int nd0;
        int sent;
        int r;
        logic [CW-1:0] w;
        logic [15:0]   top16;
        logic [23:0]   top24;

        bus.start = 1'b0; bus.data_valid = 1'b0; bus.data_in = '0; bus.bias = '0;
        bus.base_addr = '0; bus.out_total = '0; bus.shift = '0;
        do_reset();

        // Full word: 1..20 -> 0x01..0x14 at address 5
        t_base = 5; t_total = 20; t_shift = 0;
        nd0 = n_done;
        drive(1'b1, 1'b0, 0, 0);
        check_eq("busy_after_start", CW'(bus.busy), CW'(1));
        for (int i = 1; i <= 20; i++) drive(1'b0, 1'b1, i, 0);
        idle(4);
        w = '0;
        for (int i = 0; i < 20; i++) w[CW-8*(i+1) +: 8] = 8'(i + 1);
        check_eq("full_addr", CW'(last_waddr), CW'(5));
        check_eq("full_data", last_wdata, w);
        check_eq("full_done_cnt", CW'(n_done - nd0), CW'(1));
        check_eq("busy_after_done", CW'(bus.busy), CW'(0));

        // Rounding: shift 1, 5 -> 3, -5 -> 0xFE (0x00 with ReLU)
        t_base = 20; t_total = 2; t_shift = 1;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 5, 0);
        drive(1'b0, 1'b1, -5, 0);
        idle(4);
        top16 = last_wdata[CW-1 -: 16];
`ifdef FC_RELU_EN
        check_eq("round_bytes", CW'(top16), CW'(16'h0300));
`else
        check_eq("round_bytes", CW'(top16), CW'(16'h03fe));
`endif

        // Saturation: 40000 -> 0x7F, -40000 -> 0x80/0x00, 20+100 -> 0x78
        t_base = 21; t_total = 3; t_shift = 0;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 40000, 0);
        drive(1'b0, 1'b1, -40000, 0);
        drive(1'b0, 1'b1, 20, 100);
        idle(4);
        top24 = last_wdata[CW-1 -: 24];
`ifdef FC_RELU_EN
        check_eq("sat_bytes", CW'(top24), CW'(24'h7f0078));
`else
        check_eq("sat_bytes", CW'(top24), CW'(24'h7f8078));
`endif

        // Partial final word: 25 outputs, extra data_valid ignored
        t_base = 100; t_total = 25; t_shift = 2;
        nw0 = n_wr; nd0 = n_done;
        drive(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 26; i++) drive(1'b0, 1'b1, rnd_data(), rnd_bias());
        idle(6);
        check_eq("partial_writes", CW'(n_wr - nw0), CW'(2));
        check_eq("partial_done",   CW'(n_done - nd0), CW'(1));
        check_eq("partial_addr",   CW'(last_waddr), CW'(101));
        check_eq("partial_zero_tail", CW'(last_wdata[CW-41:0]), CW'(0));

        // Reset mid-layer, then a clean layer at a new base
        t_base = 200; t_total = 20; t_shift = 0;
        nw0 = n_wr;
        drive(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, rnd_data(), rnd_bias());
        do_reset();
        idle(5);
        check_eq("reset_no_write", CW'(n_wr - nw0), CW'(0));
        t_base = 300;
        drive(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, rnd_data(), rnd_bias());
        idle(4);
        check_eq("after_reset_addr", CW'(last_waddr), CW'(300));

        // Start collides with data_valid: that data is dropped
        t_base = 400; t_total = 20; t_shift = 0;
        nw0 = n_wr;
        drive(1'b1, 1'b1, 99, 0);
        for (int i = 1; i <= 20; i++) drive(1'b0, 1'b1, 3 * i, 0);
        idle(4);
        check_eq("collide_writes", CW'(n_wr - nw0), CW'(1));
        check_eq("collide_first_byte", CW'(last_wdata[CW-1 -: 8]), CW'(8'h03));
        check_eq("collide_last_byte",  CW'(last_wdata[7:0]),       CW'(8'h3c));

        // Randomized layers with gaps, restarts and overrun data
        for (int l = 0; l < 40; l++) begin
            t_base  = int'($urandom_range(0, 1023));
            t_total = int'($urandom_range(1, 50));
            t_shift = int'($urandom_range(0, 15));
            drive(1'b1, 1'($urandom_range(0, 1)), rnd_data(), rnd_bias());
            sent = 0;
            while (sent < t_total) begin
                r = int'($urandom_range(0, 99));
                if (r < 3) begin
                    t_base = int'($urandom_range(0, 1023));
                    drive(1'b1, 1'($urandom_range(0, 1)), rnd_data(), rnd_bias());
                    sent = 0;
                end else if (r < 80) begin
                    drive(1'b0, 1'b1, rnd_data(), rnd_bias());
                    sent++;
                end else begin
                    drive(1'b0, 1'b0, rnd_data(), rnd_bias());
                end
            end
            if ($urandom_range(0, 2) == 0) drive(1'b0, 1'b1, rnd_data(), rnd_bias());
            idle(4);
        end

        idle(5);
        check_eq("expected_writes_left", CW'(expq.size()), CW'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fc_output_packer.md
# fc_output_packer

Downstream stage of the fully-connected MAC: consumes each finished 23-bit signed accumulator sum, adds a per-neuron bias, requantizes with round-half-up and arithmetic shift, saturates to 8 bits, and packs PACK_NUM results into one SRAM write word. The packed word layout matches the next layer's `src_window` input format, with element 0 in the most significant byte. The block is driven by the layer controller through `start`, and it issues single-cycle SRAM writes.

## Interface
- PACK_NUM, 20, results per SRAM word
- DATA_WIDTH, 8, output element width
- IN_WIDTH, 23, accumulator width
- BIAS_WIDTH, 16, bias width
- ADDR_W, 10, SRAM address width
- clk  input  1  clock
- srstn  input  1  synchronous reset, active-low
- start  input  1  one-cycle pulse; loads `base_addr`, `out_total`, `shift`; clears counters
- base_addr  input  ADDR_W  first write address
- out_total  input  10  number of outputs in the layer, 1..1023
- shift  input  4  right-shift amount, 0..15
- data_valid  input  1  `data_in`/`bias` valid this cycle
- data_in  input  IN_WIDTH  signed accumulator sum
- bias  input  BIAS_WIDTH  signed bias for this output
- sram_wen  output  1  write enable, active-low
- sram_waddr  output  ADDR_W  write address
- sram_wdata  output  PACK_NUM*DATA_WIDTH  packed word
- busy  output  1  high from the cycle after `start` until the cycle after `done`
- done  output  1  one-cycle pulse, coincident with the final write

## Operation
- **States**
  - IDLE: `start` → RUN.
  - RUN: `data_valid` accepted while received < `out_total`; the last accepted output → DRAIN.
  - DRAIN: waits for the final write to issue, pulses `done`, then returns to IDLE.
- **Arithmetic (24-bit signed)**
  - s = sext(`data_in`) + sext(`bias`).
  - If shift > 0: s += 1 << (shift−1); then r = s >>> shift.
  - Saturate r to [−128, 127], or per the macro in Configuration.
- **Packing**
  - The slot counter runs 0..PACK_NUM−1; slot i is placed at bits [DATA_WIDTH*(PACK_NUM−1−i) +: DATA_WIDTH].
  - A word is written when slot PACK_NUM−1 fills, or when the final output of the layer lands.
  - In a partial final word, unfilled slots are 0.
  - After each write, the address increments by 1 and the pack buffer clears.
- A separate write register holds the outgoing word, so the pack buffer accepts a new result in the same cycle a write is issued.
- `data_valid` is ignored in IDLE, in DRAIN, and after `out_total` outputs have been received.
- `start` while busy restarts the layer; the in-flight pipeline contents and the partial word are discarded.
- If `start` and `data_valid` arrive in the same cycle, `start` wins and the data is dropped.

## Timing
- **Reset values:** `sram_wen`=1, `sram_waddr`=0, `sram_wdata`=0, `busy`=0, `done`=0; state IDLE; all counters and buffers 0.
- **Pipeline**
  - Edge E0: data sampled; stage-1 register holds the shifted 24-bit value.
  - Edge E1: saturated byte written into the pack buffer.
  - Edge E2: if the word is complete, `sram_wen`=0 with valid `sram_waddr`/`sram_wdata` for exactly one cycle.
- Latency is 3 edges from `data_valid` to the write cycle.
- Throughput is one result per cycle; `data_valid` may be held high continuously.
- A reset mid-layer aborts immediately: no write is issued, the next cycle shows reset values, and a subsequent `start` behaves normally.

## Configuration
- `FC_RELU_EN` defined: ReLU is applied, r is clamped to [0, 127], and negative values become 0.
- `FC_RELU_EN` undefined: signed saturation to [−128, 127], stored in two's complement.

## Structure
- Package `fc_pkg`:
  - localparams for the widths above;
  - the 24-bit internal sum width;
  - state enum {IDLE, RUN, DRAIN}.
- Sub-module `fc_requant`: bias add, rounding, shift, and saturate/ReLU, with the stage-1 register inside; its output is one byte.
- The top level holds the FSM, slot/output/address counters, pack buffer, and write register.

## Test plan
- **Full word:** `start` (base 5, total 20, shift 0); bias 0; `data_in` 1..20 on consecutive cycles → one write at addr 5, bytes 0x01..0x14 MSB-first, `done` in the same cycle.
- **Rounding:** shift 1; `data_in`=5 → 3; `data_in`=−5 → 0 with `FC_RELU_EN`, 0xFE without.
- **Saturation:** shift 0; `data_in`=40000 → 0x7F; `data_in`=−40000 → 0x00 with `FC_RELU_EN`, 0x80 without; bias 100 + `data_in` 20 → 0x78.
- **Partial word:** total 25 → writes at base and base+1; the second holds 5 bytes followed by 15 zero bytes; `done` only on the second write; a 26th `data_valid` is ignored.
- **Reset mid-layer:** `srstn` low after 10 inputs → no write, `busy`=0; a new `start` with total 20 produces a correct word at the new base.
- **Start collision:** `start` and `data_valid` in the same cycle → the data is dropped; the word holds only the following 20 inputs.
